// File: rtl/fft_pkg.sv
// Shared types and address math for the in-place radix-2 DIT FFT stage sequencer.
package fft_pkg;
  localparam int MAX_LOG2N = 12;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, NEXT} state_e;

  typedef struct packed {
    logic [MAX_LOG2N-1:0] addr0;
    logic [MAX_LOG2N-1:0] addr1;
    logic [MAX_LOG2N-1:0] tw;
  } btfly_addr_t;

  function automatic int fft_n(input int log2n);
    return 1 << log2n;
  endfunction

  // Butterfly b of stage s: pairs are span apart inside groups of 2*span.
  function automatic btfly_addr_t btfly_addr(input logic [MAX_LOG2N-1:0] b,
                                             input logic [3:0] s,
                                             input int log2n);
    logic [MAX_LOG2N-1:0] span, pos, grp;
    btfly_addr_t r;
    span    = MAX_LOG2N'(1) << s;
    pos     = b & (span - 1'b1);
    grp     = b >> s;
    r.addr0 = (grp << (s + 1)) | pos;
    r.addr1 = r.addr0 + span;
    r.tw    = pos << (log2n - 1 - int'(s));
    return r;
  endfunction
endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (b, s) -> RAM pair and twiddle index.
module fft_addr_gen import fft_pkg::*; #(
  parameter int LOG2N = 3,
  parameter int SW    = $clog2(LOG2N)
) (
  input  logic [LOG2N-1:0] b,
  input  logic [SW-1:0]    s,
  output logic [LOG2N-1:0] addr0,
  output logic [LOG2N-1:0] addr1,
  output logic [LOG2N-2:0] tw
);
  btfly_addr_t r;

  always_comb begin
    r     = btfly_addr(MAX_LOG2N'(b), 4'(s), LOG2N);
    addr0 = r.addr0[LOG2N-1:0];
    addr1 = r.addr1[LOG2N-1:0];
    tw    = r.tw[LOG2N-2:0];
  end
endmodule

// File: rtl/fft_stage_ctrl.sv
// Radix-2 DIT FFT stage sequencer: issues N/2 butterflies per stage, counts
// write-backs from the butterfly's output valid, and serializes stages.
module fft_stage_ctrl import fft_pkg::*; #(
  parameter int LOG2N = 3,
  parameter int SW    = $clog2(LOG2N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_rd_en,
  output logic [LOG2N-1:0] o_rd_addr0,
  output logic [LOG2N-1:0] o_rd_addr1,
  output logic [LOG2N-2:0] o_tw_addr,
  output logic             o_btfly_valid,
  input  logic             i_btfly_valid_out,
  output logic             o_wr_en,
  output logic [LOG2N-1:0] o_wr_addr0,
  output logic [LOG2N-1:0] o_wr_addr1,
  output logic [SW-1:0]    o_stage
);
  localparam int               HALF   = fft_n(LOG2N) / 2;
  localparam logic [LOG2N-1:0] LAST_B = LOG2N'(HALF - 1);
  localparam logic [SW-1:0]    LAST_S = SW'(LOG2N - 1);

  state_e           state;
  logic [LOG2N-1:0] rd_b, wr_b;
  logic [LOG2N-1:0] rd_a0, rd_a1, wr_a0, wr_a1;
  logic [LOG2N-2:0] rd_tw, wr_tw;
  logic             wr_last;

  fft_addr_gen #(.LOG2N(LOG2N), .SW(SW)) u_rd_gen (
    .b(rd_b), .s(o_stage), .addr0(rd_a0), .addr1(rd_a1), .tw(rd_tw)
  );

  // Write side mirrors the read side, indexed by the write-back count.
  fft_addr_gen #(.LOG2N(LOG2N), .SW(SW)) u_wr_gen (
    .b(wr_b), .s(o_stage), .addr0(wr_a0), .addr1(wr_a1), .tw(wr_tw)
  );

  assign o_rd_en    = (state == ISSUE);
  assign o_rd_addr0 = o_rd_en ? rd_a0 : '0;
  assign o_rd_addr1 = o_rd_en ? rd_a1 : '0;

  // Butterfly output valid only counts while a stage is in flight.
  assign o_wr_en    = i_btfly_valid_out && (state == ISSUE || state == DRAIN);
  assign o_wr_addr0 = o_wr_en ? wr_a0 : '0;
  assign o_wr_addr1 = o_wr_en ? wr_a1 : '0;
  assign wr_last    = o_wr_en && (wr_b == LAST_B);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_b          <= '0;
      wr_b          <= '0;
      o_stage       <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_btfly_valid <= 1'b0;
      o_tw_addr     <= '0;
    end else begin
      o_done        <= 1'b0;
      // RAM read latency is one cycle; twiddle and valid line up with the data.
      o_btfly_valid <= o_rd_en;
      o_tw_addr     <= o_rd_en ? rd_tw : '0;
      if (o_wr_en) wr_b <= wr_b + 1'b1;
      case (state)
        IDLE: if (i_start) begin
          state   <= ISSUE;
          o_busy  <= 1'b1;
          o_stage <= '0;
          rd_b    <= '0;
          wr_b    <= '0;
        end
        ISSUE: begin
          if (rd_b == LAST_B) state <= DRAIN;
          else                rd_b  <= rd_b + 1'b1;
        end
        DRAIN: if (wr_last) begin
          state  <= NEXT;
          o_done <= (o_stage == LAST_S);
        end
        NEXT: begin
          if (o_stage == LAST_S) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            state   <= ISSUE;
            o_stage <= o_stage + 1'b1;
            rd_b    <= '0;
            wr_b    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Randomized-latency bench for fft_stage_ctrl against a group/offset FFT schedule model.
module tb_fft_stage_ctrl;
  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;
  localparam int HALF  = N / 2;
  localparam int SW    = $clog2(LOG2N);

  logic             clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_btfly_valid_out = 1'b0;
  logic             o_busy, o_done, o_rd_en, o_btfly_valid, o_wr_en;
  logic [LOG2N-1:0] o_rd_addr0, o_rd_addr1, o_wr_addr0, o_wr_addr1;
  logic [LOG2N-2:0] o_tw_addr;
  logic [SW-1:0]    o_stage;

  always #5 clk = ~clk;

  fft_stage_ctrl #(.LOG2N(LOG2N), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_rd_en(o_rd_en), .o_rd_addr0(o_rd_addr0), .o_rd_addr1(o_rd_addr1),
    .o_tw_addr(o_tw_addr), .o_btfly_valid(o_btfly_valid),
    .i_btfly_valid_out(i_btfly_valid_out), .o_wr_en(o_wr_en),
    .o_wr_addr0(o_wr_addr0), .o_wr_addr1(o_wr_addr1), .o_stage(o_stage)
  );

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected schedule: for each stage, walk groups of 2*span, pairing j with j+span.
  typedef struct { int a0; int a1; int tw; int s; } bf_t;
  bf_t rdq[$], twq[$], wrq[$];
  int  n_rd, n_wr, n_done, last_wr_cyc, done_cyc;
  int  cyc = 0;
  logic prev_rd = 1'b0, prev_done = 1'b0;

  task automatic build_model();
    rdq.delete(); twq.delete(); wrq.delete();
    n_rd = 0; n_wr = 0; n_done = 0; last_wr_cyc = 0; done_cyc = 0;
    for (int s = 0; s < LOG2N; s++) begin
      int span;
      span = 1 << s;
      for (int g = 0; g < N; g += 2 * span)
        for (int j = 0; j < span; j++) begin
          bf_t e;
          e.a0 = g + j; e.a1 = g + j + span; e.tw = j * (N / (2 * span)); e.s = s;
          rdq.push_back(e);
          wrq.push_back(e);
        end
    end
  endtask

  // Butterfly model: output valid is input valid delayed by lat cycles.
  int          lat = 6;
  logic [15:0] vpipe = '0;
  logic        spurious = 1'b0;
  always @(posedge clk) begin
    #1 i_btfly_valid_out = vpipe[lat-1] | spurious;
  end

  always @(negedge clk) begin
    bf_t e;
    cyc++;
    vpipe = rst_n ? {vpipe[14:0], o_btfly_valid} : '0;
    chk("vld_align", o_btfly_valid, prev_rd);
    if (o_btfly_valid) begin
      chk("tw_pending", 32'(twq.size() != 0), 1);
      if (twq.size() != 0) begin
        e = twq.pop_front();
        chk("tw_addr", o_tw_addr, e.tw);
      end
    end
    if (o_rd_en) begin
      chk("rd_pending", 32'(rdq.size() != 0), 1);
      if (rdq.size() != 0) begin
        e = rdq.pop_front();
        chk("rd_addr0", o_rd_addr0, e.a0);
        chk("rd_addr1", o_rd_addr1, e.a1);
        chk("rd_stage", o_stage, e.s);
        chk("rd_after_wr", 32'(n_wr >= e.s * HALF), 1);
        twq.push_back(e);
        n_rd++;
      end
    end
    prev_rd = o_rd_en;
    if (o_wr_en) begin
      chk("wr_pending", 32'(wrq.size() != 0), 1);
      if (wrq.size() != 0) begin
        e = wrq.pop_front();
        chk("wr_addr0", o_wr_addr0, e.a0);
        chk("wr_addr1", o_wr_addr1, e.a1);
      end
      n_wr++;
      last_wr_cyc = cyc;
    end
    if (o_done) begin
      n_done++;
      done_cyc = cyc;
      chk("done_wr_count", n_wr, LOG2N * HALF);
      chk("done_after_wr", cyc - last_wr_cyc, 1);
    end
    if (prev_done) chk("busy_fall", o_busy, 0);
    prev_done = o_done;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_rd_en"}, o_rd_en, 0);
    chk({tag, "_rd0"}, o_rd_addr0, 0);
    chk({tag, "_rd1"}, o_rd_addr1, 0);
    chk({tag, "_tw"}, o_tw_addr, 0);
    chk({tag, "_bvalid"}, o_btfly_valid, 0);
    chk({tag, "_wr_en"}, o_wr_en, 0);
    chk({tag, "_wr0"}, o_wr_addr0, 0);
    chk({tag, "_wr1"}, o_wr_addr1, 0);
    chk({tag, "_stage"}, o_stage, 0);
  endtask

  task automatic start_pulse(output int t0);
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); t0 = cyc; #1 i_start = 1'b0;
    @(negedge clk);
    chk("busy_rise", o_busy, 1);
    chk("rd_en_first", o_rd_en, 1);
  endtask

  task automatic run(input int l, input bit poke);
    int t0, guard;
    lat = l;
    build_model();
    start_pulse(t0);
    guard = 0;
    while (n_done == 0 && guard < 400) begin
      @(posedge clk);
      guard++;
      if (poke && guard == 5) begin
        #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        guard++;
      end
    end
    chk("done_seen", n_done, 1);
    chk("total_cycles", done_cyc - t0, LOG2N * (HALF + l + 2));
    repeat (2) @(negedge clk);
    chk("done_once", n_done, 1);
    chk("idle_busy", o_busy, 0);
    chk("rd_all_issued", rdq.size(), 0);
    chk("wr_all_done", wrq.size(), 0);
  endtask

  initial begin
    int t0, found;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    run(6, 1'b1);

    // Spurious butterfly valid while idle: no write, no count, no start.
    @(posedge clk); spurious = 1'b1;
    @(negedge clk);
    chk("idle_wr_en", o_wr_en, 0);
    @(posedge clk); spurious = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_wr_count", n_wr, LOG2N * HALF);
    chk("idle_no_start", o_rd_en, 0);
    chk("idle_no_busy", o_busy, 0);

    for (int k = 0; k < 3; k++) run(int'($urandom_range(1, 8)), 1'b0);

    // Abort during stage 1 drain, then restart from scratch.
    lat = 6;
    build_model();
    start_pulse(t0);
    found = 0;
    for (int g = 0; g < 200 && found == 0; g++) begin
      @(negedge clk);
      if (o_stage == SW'(1) && o_busy && !o_rd_en) found = 1;
    end
    chk("reach_stage1_drain", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    repeat (3) @(negedge clk);
    chk("abort_no_done", n_done, 0);
    rst_n = 1'b1;
    run(6, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
